// File: rtl/rom_infr.sv
// 32x4 constant lookup table with a registered read address.
// One clock of read latency; data is a combinational decode of raddr.
module rom_infr (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] addr,
    output logic [3:0] data
);

    logic [4:0] raddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr <= 5'd0;
        end else if (en) begin
            raddr <= addr;
        end
    end

    // Upper half of the address space aliases the lower half.
    always_comb begin
        data = 4'b0010;
        case (raddr)
            5'd0,  5'd16: data = 4'b0010;
            5'd1,  5'd17: data = 4'b0010;
            5'd2,  5'd18: data = 4'b1110;
            5'd3,  5'd19: data = 4'b0010;
            5'd4,  5'd20: data = 4'b0100;
            5'd5,  5'd21: data = 4'b1010;
            5'd6,  5'd22: data = 4'b1100;
            5'd7,  5'd23: data = 4'b0000;
            5'd8,  5'd24: data = 4'b1010;
            5'd9,  5'd25: data = 4'b0010;
            5'd10, 5'd26: data = 4'b1110;
            5'd11, 5'd27: data = 4'b0010;
            5'd12, 5'd28: data = 4'b0100;
            5'd13, 5'd29: data = 4'b1010;
            5'd14, 5'd30: data = 4'b1100;
            5'd15, 5'd31: data = 4'b0000;
            default:      data = 4'b0010;
        endcase
    end

endmodule

// File: tb/tb_rom_infr.sv
// Self-checking bench for rom_infr: a table-driven reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_rom_infr;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] addr;
    logic [3:0] data;

    int checks   = 0;
    int failures = 0;

    logic [3:0] rom_tbl [16] = '{4'h2, 4'h2, 4'he, 4'h2, 4'h4, 4'ha, 4'hc, 4'h0,
                                 4'ha, 4'h2, 4'he, 4'h2, 4'h4, 4'ha, 4'hc, 4'h0};

    logic [4:0] m_raddr;
    logic       model_valid = 1'b0;

    rom_infr dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .addr (addr),
        .data (data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // reference model: address the word was last selected with
    always @(posedge clk) begin
        if (rst) begin
            m_raddr     <= 5'd0;
            model_valid <= 1'b1;
        end else if (en) begin
            m_raddr <= addr;
        end
    end

    // compare process, away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_data", int'(data), int'(rom_tbl[m_raddr[3:0]]));
            chk("model_raddr", int'(dut.raddr), int'(m_raddr));
        end
    end

    // driver
    task automatic step(input logic r, input logic e, input logic [4:0] a);
        rst  = r;
        en   = e;
        addr = a;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] seq_a [7] = '{5'd0, 5'd2, 5'd5, 5'd10, 5'd15, 5'd9, 5'd4};
    logic [3:0] seq_d [7] = '{4'b0010, 4'b1110, 4'b1010, 4'b1110, 4'b0000, 4'b0010, 4'b0100};
    logic [4:0] al_a  [4] = '{5'd24, 5'd8, 5'd18, 5'd31};
    logic [3:0] al_d  [4] = '{4'b1010, 4'b1010, 4'b1110, 4'b0000};

    initial begin
        rst  = 1'b0;
        en   = 1'b0;
        addr = 5'd0;
        @(negedge clk);

        // reset beats enable
        step(1'b1, 1'b1, 5'd10);
        chk("reset_raddr", int'(dut.raddr), 0);
        chk("reset_data", int'(data), 4'b0010);

        // sequential reads, with addr changed mid-cycle to show one-cycle lag
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, seq_a[i]);
            chk("seq_data", int'(data), int'(seq_d[i]));
            if (i < 6) begin
                addr = seq_a[i+1];
                #1;
                chk("seq_hold_before_edge", int'(data), int'(seq_d[i]));
            end
        end

        // enable hold
        step(1'b0, 1'b1, 5'd2);
        chk("hold_load", int'(data), 4'b1110);
        step(1'b0, 1'b0, 5'd5);
        chk("hold_data_a", int'(data), 4'b1110);
        step(1'b0, 1'b0, 5'd7);
        chk("hold_data_b", int'(data), 4'b1110);
        step(1'b0, 1'b0, 5'd31);
        chk("hold_data_c", int'(data), 4'b1110);
        chk("hold_raddr", int'(dut.raddr), 2);
        step(1'b0, 1'b1, 5'd4);
        chk("hold_release", int'(data), 4'b0100);

        // aliasing
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, al_a[i]);
            chk("alias_data", int'(data), int'(al_d[i]));
        end

        // full sweep with a one-edge reset at addr 6
        for (int a = 0; a < 32; a++) begin
            if (a == 6) begin
                step(1'b1, 1'b1, 5'(a));
                chk("sweep_reset_data", int'(data), 4'b0010);
                chk("sweep_reset_raddr", int'(dut.raddr), 0);
            end
            step(1'b0, 1'b1, 5'(a));
            chk("sweep_data", int'(data), int'(rom_tbl[a % 16]));
            chk("sweep_raddr", int'(dut.raddr), a);
        end

        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
